// File: rtl/mem_bus_if.sv
// CPU load/store to memory-port bus stage: one request becomes one CS-strobed
// transaction with a synchronized ready handshake and lane-extended read data.
module mem_bus_if #(
  parameter int READY_MODE = 0,
  parameter int LAT_CYCLES = 16,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sext,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic        mem_cs,
  output logic        mem_rw,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, WAIT, DONE
  } state_e;

  localparam logic [TO_W-1:0] LAT_LAST = TO_W'(LAT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sext_q, sext_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wd_q, wd_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            cs_q, cs_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            sync1_q, rdy_s_q, rdy_q;
  logic            rdy_rise, mis;
  logic [3:0]      be_n;
  logic [31:0]     wd_n, sh, ext;

  assign rdy_rise = rdy_s_q & ~rdy_q;

  always_comb begin
    mis  = 1'b0;
    be_n = 4'b1111;
    wd_n = cpu_wdata;
    unique case (cpu_size)
      2'b00: begin
        be_n = 4'b0001 << cpu_addr[1:0];
        wd_n = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        mis  = cpu_addr[0];
        be_n = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{cpu_wdata[15:0]}};
      end
      2'b10: mis = |cpu_addr[1:0];
      default: mis = 1'b1;
    endcase
  end

  // Aligned lane lands in the low bits after the shift.
  always_comb begin
    sh  = mem_rdata >> {addr_q[1:0], 3'b000};
    ext = mem_rdata;
    unique case (size_q)
      2'b00:   ext = {{24{sext_q & sh[7]}}, sh[7:0]};
      2'b01:   ext = {{16{sext_q & sh[15]}}, sh[15:0]};
      default: ext = mem_rdata;
    endcase
    if (we_q) ext = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    err_d   = 1'b0;
    rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d   = cpu_we;
          size_d = cpu_size;
          sext_d = cpu_sext;
          addr_d = cpu_addr;
          be_d   = be_n;
          wd_d   = wd_n;
          if (mis) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = STROBE;
      STROBE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (READY_MODE != 0) begin
          if (cnt_q == LAT_LAST) begin
            state_d = DONE;
            rdata_d = ext;
          end
        end else if (rdy_rise) begin
          state_d = DONE;
          rdata_d = ext;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobe/ack/busy are registered so the memory never sees decode glitches.
    cs_d   = (state_d == STROBE) || (state_d == WAIT);
    ack_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      sync1_q <= 1'b0;
      rdy_s_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      sync1_q <= mem_ready;
      rdy_s_q <= sync1_q;
      rdy_q   <= rdy_s_q;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_busy  = busy_q;
  assign mem_cs    = cs_q;
  assign mem_rw    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q[31:2];
  assign mem_wdata = wd_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if: fixed-latency, timeout and ready-edge
// instances share the CPU-side stimulus and are run one at a time.
module tb_mem_bus_if;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [2:0]  req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_sext;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [2:0]  ack, err, busy, cs, rw;
  logic [31:0] rd [3];
  logic [31:0] wdo [3];
  logic [3:0]  be [3];
  logic [29:0] ad [3];

  int pass_cnt = 0;
  int tot = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_bus_if #(
      .READY_MODE(g == 0 ? 1 : 0),
      .LAT_CYCLES(4),
      .TIMEOUT(g == 1 ? 10 : 255),
      .TO_W(8)
    ) u_dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(req[g]), .cpu_we(cpu_we), .cpu_size(cpu_size),
      .cpu_sext(cpu_sext), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(rd[g]), .cpu_ack(ack[g]), .cpu_err(err[g]),
      .cpu_busy(busy[g]), .mem_cs(cs[g]), .mem_rw(rw[g]),
      .mem_be(be[g]), .mem_addr(ad[g]), .mem_wdata(wdo[g]),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );
  end

  // Issues one request; ack_cyc counts cycles after the accept edge (1 = next cycle).
  task automatic run_txn(
    input int inst, input logic we, input logic [1:0] size,
    input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
    output int ack_cyc, output int cs_cyc, output logic [31:0] rdo,
    output logic erro, output logic [3:0] beo, output logic rwo,
    output logic [29:0] ado, output logic [31:0] wdq
  );
    @(posedge Clk); #1;
    cpu_we = we; cpu_size = size; cpu_sext = sext;
    cpu_addr = addr; cpu_wdata = wdata;
    req[inst] = 1'b1;
    @(posedge Clk); #1;
    req[inst] = 1'b0;
    beo = be[inst]; rwo = rw[inst]; ado = ad[inst]; wdq = wdo[inst];
    ack_cyc = -1; cs_cyc = 0; rdo = 'x; erro = 1'bx;
    for (int c = 1; c <= 400; c++) begin
      if (cs[inst]) cs_cyc++;
      if (ack[inst]) begin
        ack_cyc = c; rdo = rd[inst]; erro = err[inst];
        break;
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset;
    @(posedge Clk); #1;
    tot++;
    if ({cs[0], busy[0], ack[0], err[0], rw[0]} !== 5'b0) $display("FAIL reset_ctl got %b want 00000", {cs[0], busy[0], ack[0], err[0], rw[0]});
    else pass_cnt++;
    tot++;
    if ({rd[0], wdo[0], be[0], ad[0]} !== 98'b0) $display("FAIL reset_data got %h want 0", {rd[0], wdo[0], be[0], ad[0]});
    else pass_cnt++;
    tot++;
    if ({cs[1], cs[2], busy[1], busy[2], ack[1], ack[2]} !== 6'b0) $display("FAIL reset_other got %b want 0", {cs[1], cs[2], busy[1], busy[2], ack[1], ack[2]});
    else pass_cnt++;
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic test_word_load;
    int a, c; logic [31:0] r, w; logic e, rwv; logic [3:0] b; logic [29:0] ma;
    mem_rdata = 32'h1234_5678;
    run_txn(0, 1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0, a, c, r, e, b, rwv, ma, w);
    tot++; if (ma !== 30'h9) $display("FAIL wl_addr got %h want 9", ma); else pass_cnt++;
    tot++; if (b !== 4'b1111) $display("FAIL wl_be got %b want 1111", b); else pass_cnt++;
    tot++; if (rwv !== 1'b0) $display("FAIL wl_rw got %b want 0", rwv); else pass_cnt++;
    tot++; if (c !== 5) $display("FAIL wl_cs_len got %0d want 5", c); else pass_cnt++;
    tot++; if (a !== 7) $display("FAIL wl_latency got %0d want 7", a); else pass_cnt++;
    tot++; if (r !== 32'h1234_5678) $display("FAIL wl_rdata got %h want 12345678", r); else pass_cnt++;
    tot++; if (e !== 1'b0) $display("FAIL wl_err got %b want 0", e); else pass_cnt++;
  endtask

  task automatic test_byte_half;
    int a, c; logic [31:0] r, w; logic e, rwv; logic [3:0] b; logic [29:0] ma;
    mem_rdata = 32'h80FF_0000;
    run_txn(0, 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, a, c, r, e, b, rwv, ma, w);
    tot++; if (b !== 4'b1000) $display("FAIL bs_be got %b want 1000", b); else pass_cnt++;
    tot++; if (r !== 32'hFFFF_FF80) $display("FAIL bs_rdata got %h want ffffff80", r); else pass_cnt++;
    run_txn(0, 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, a, c, r, e, b, rwv, ma, w);
    tot++; if (r !== 32'h0000_0080) $display("FAIL bz_rdata got %h want 00000080", r); else pass_cnt++;
    run_txn(0, 1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h0000_BEEF, a, c, r, e, b, rwv, ma, w);
    tot++; if (b !== 4'b1100) $display("FAIL hs_be got %b want 1100", b); else pass_cnt++;
    tot++; if (w !== 32'hBEEF_BEEF) $display("FAIL hs_wdata got %h want beefbeef", w); else pass_cnt++;
    tot++; if (rwv !== 1'b1) $display("FAIL hs_rw got %b want 1", rwv); else pass_cnt++;
    tot++; if ({r, e} !== 33'h0) $display("FAIL hs_rdata_err got %h want 0", {r, e}); else pass_cnt++;
    mem_rdata = 32'h8001_7FFF;
    run_txn(0, 1'b0, 2'b01, 1'b1, 32'h0000_0042, 32'h0, a, c, r, e, b, rwv, ma, w);
    tot++; if (r !== 32'hFFFF_8001) $display("FAIL hl_rdata got %h want ffff8001", r); else pass_cnt++;
  endtask

  task automatic test_misaligned;
    int a, c; logic [31:0] r, w; logic e, rwv; logic [3:0] b; logic [29:0] ma;
    logic [1:0] sz [2];
    logic [31:0] adr [2];
    sz[0] = 2'b10; adr[0] = 32'h0000_0006;
    sz[1] = 2'b11; adr[1] = 32'h0000_0008;
    for (int i = 0; i < 2; i++) begin
      run_txn(0, 1'b0, sz[i], 1'b0, adr[i], 32'h0, a, c, r, e, b, rwv, ma, w);
      tot++; if (a !== 1) $display("FAIL mis%0d_latency got %0d want 1", i, a); else pass_cnt++;
      tot++; if (e !== 1'b1) $display("FAIL mis%0d_err got %b want 1", i, e); else pass_cnt++;
      tot++; if (c !== 0) $display("FAIL mis%0d_cs got %0d want 0", i, c); else pass_cnt++;
    end
  endtask

  task automatic test_timeout;
    int a, c; logic [31:0] r, w; logic e, rwv; logic [3:0] b; logic [29:0] ma;
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    run_txn(1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, a, c, r, e, b, rwv, ma, w);
    tot++; if (e !== 1'b1) $display("FAIL to_err got %b want 1", e); else pass_cnt++;
    tot++; if (c !== 11) $display("FAIL to_cs_len got %0d want 11", c); else pass_cnt++;
    tot++; if (a !== 13) $display("FAIL to_latency got %0d want 13", a); else pass_cnt++;
    tot++; if (r !== 32'h0) $display("FAIL to_rdata got %h want 0", r); else pass_cnt++;
    // Ready already high on entry must not count as completion.
    mem_ready = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    run_txn(1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, a, c, r, e, b, rwv, ma, w);
    tot++; if (e !== 1'b1) $display("FAIL rh_err got %b want 1", e); else pass_cnt++;
    tot++; if (a !== 13) $display("FAIL rh_latency got %0d want 13", a); else pass_cnt++;
    mem_ready = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic test_ready_rise;
    int a, c, k; logic [31:0] r, w; logic e, rwv; logic [3:0] b; logic [29:0] ma;
    mem_rdata = 32'hCAFE_F00D;
    k = 0;
    fork
      run_txn(2, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, a, c, r, e, b, rwv, ma, w);
      begin
        while (!cs[2] && k < 50) begin @(posedge Clk); #1; k++; end
        #154 mem_ready = 1'b1;
      end
    join
    mem_ready = 1'b0;
    tot++; if (e !== 1'b0) $display("FAIL rr_err got %b want 0", e); else pass_cnt++;
    tot++; if (a < 19 || a > 21) $display("FAIL rr_latency got %0d want 19..21", a); else pass_cnt++;
    tot++; if (r !== 32'hCAFE_F00D) $display("FAIL rr_rdata got %h want cafef00d", r); else pass_cnt++;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset_mid_wait;
    int a, c, seen; logic [31:0] r, w; logic e, rwv; logic [3:0] b; logic [29:0] ma;
    @(posedge Clk); #1;
    cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h0000_0030;
    req[0] = 1'b1;
    @(posedge Clk); #1;
    req[0] = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    tot++; if (cs[0] !== 1'b1) $display("FAIL rm_pre_cs got %b want 1", cs[0]); else pass_cnt++;
    #2 Reset = 1'b1;
    #1;
    tot++; if ({cs[0], busy[0], ack[0]} !== 3'b000) $display("FAIL rm_async got %b want 000", {cs[0], busy[0], ack[0]}); else pass_cnt++;
    @(posedge Clk); #1;
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (ack[0]) seen++;
      @(posedge Clk); #1;
    end
    tot++; if (seen !== 0) $display("FAIL rm_no_ack got %0d want 0", seen); else pass_cnt++;
    mem_rdata = 32'h0BAD_F00D;
    run_txn(0, 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, a, c, r, e, b, rwv, ma, w);
    tot++; if (a !== 7) $display("FAIL rm_latency got %0d want 7", a); else pass_cnt++;
    tot++; if (r !== 32'h0BAD_F00D) $display("FAIL rm_rdata got %h want 0badf00d", r); else pass_cnt++;
    tot++; if (e !== 1'b0) $display("FAIL rm_err got %b want 0", e); else pass_cnt++;
  endtask

  initial begin
    Reset = 1'b1;
    req = '0;
    cpu_we = 1'b0; cpu_size = 2'b00; cpu_sext = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_word_load();
    test_byte_half();
    test_misaligned();
    test_timeout();
    test_ready_rise();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- Synchronous bus-interface stage sitting directly upstream of the simulated memory, between the CPU load/store unit and the memory port.
- Converts single CPU load/store requests (byte/half/word, byte address) into one memory transaction: word address, byte enables, RW, a CS strobe and lane-aligned write data.
- Waits for memory completion, extracts and sign/zero-extends read data, and returns a one-cycle acknowledge to the CPU.
- Flags misaligned, reserved-size and timed-out accesses.

Parameters:
- READY_MODE, 0: completion source. 0 = rising edge of synchronized mem_ready; 1 = fixed latency.
- LAT_CYCLES, 16: cycles CS is held before completion when READY_MODE=1 (minimum 1).
- TIMEOUT, 255: maximum cycles in WAIT when READY_MODE=0 before aborting with error.
- TO_W, 8: width of wait counter; must hold max(LAT_CYCLES, TIMEOUT).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high.
- cpu_req  in  1  request level, sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- cpu_sext  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-justified.
- cpu_rdata  out  32  load result, valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  qualifies cpu_ack: misaligned, reserved size or timeout.
- cpu_busy  out  1  high from accept through the ack cycle.
- mem_cs  out  1  memory chip select (memory acts on its rising edge).
- mem_rw  out  1  1 = write, 0 = read.
- mem_be  out  4  byte enables.
- mem_addr  out  30  word address, cpu_addr[31:2].
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  memory read data.
- mem_ready  in  1  memory DataReady; asynchronous to Clk.

Behaviour:
- Reset (async): state IDLE; every output 0; synchronizer flops and counter 0. Reset during any state drops mem_cs immediately; no ack is issued for the aborted access.
- mem_ready passes through a 2-flop synchronizer (rdy_s). Edge detection uses a third flop: rdy_rise = rdy_s & ~rdy_q.
- FSM states: IDLE, SETUP, STROBE, WAIT, DONE.
- IDLE:
  - cpu_req=1 → latch we/size/sext/addr/wdata; set cpu_busy=1.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 → DONE with err=1; no memory access.
  - Otherwise → SETUP.
- SETUP (1 cycle): drive mem_addr, mem_rw, mem_be, mem_wdata with mem_cs=0, giving one cycle of setup before the CS edge.
  - Byte: be = 0001 << addr[1:0]; wdata byte replicated to all four lanes.
  - Half: be = 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata half replicated to both lanes.
  - Word: be = 1111.
- STROBE (1 cycle): mem_cs=1; clear counter → WAIT.
- WAIT: mem_cs held 1; counter increments each cycle.
  - READY_MODE=0: rdy_rise → DONE. If counter reaches TIMEOUT → DONE with err=1.
  - READY_MODE=1: counter reaches LAT_CYCLES-1 → DONE.
  - Address, BE, RW and wdata stay stable throughout.
- DONE (1 cycle):
  - mem_cs=0; cpu_ack=1; cpu_err per above.
  - Loads: cpu_rdata = selected lane from mem_rdata captured on the WAIT→DONE transition. Byte lane = addr[1:0]; half lane = addr[1]. Extend to 32 bits per sext. Word passes unchanged.
  - Stores or err: cpu_rdata=0.
  - Next state IDLE; cpu_busy drops the following cycle.
  - Back-to-back requests are accepted no earlier than IDLE, so a new transaction always carries at least 2 cycles of CS low between strobes.
- Latency, READY_MODE=1, aligned request: accept edge → ack = LAT_CYCLES+3 cycles.
- Latency, misaligned request: ack 1 cycle after accept.
- cpu_req changes while busy are ignored. mem_ready activity outside WAIT is ignored.
- Ready already high when WAIT is entered does not complete the access (edge required); the access times out instead.

Test Plan:
- READY_MODE=1, LAT_CYCLES=4, word load at 0x0000_0024, mem_rdata=0x1234_5678 → mem_addr=0x9, mem_be=1111, mem_rw=0, one CS pulse of 5 cycles, ack 7 cycles after accept, cpu_rdata=0x1234_5678, err=0.
- Byte load, sext=1, addr=0x0000_0013, mem_rdata=0x80FF_0000 → be=1000, cpu_rdata=0xFFFF_FF80. Same access with sext=0 → 0x0000_0080.
- Half store, addr=0x0000_0042, wdata=0x0000_BEEF → mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_rw=1.
- Word load at 0x0000_0006 → ack+err on the cycle after accept; mem_cs never asserts. Size=11 gives the same result.
- READY_MODE=0, TIMEOUT=10, mem_ready held 0 → ack with err=1 after 10 WAIT cycles. Repeat with mem_ready rising 155 ns after CS (10 ns clock) → ack, err=0, 2–3 cycles after the synchronized rise.
- Reset asserted mid-WAIT → mem_cs, cpu_busy and cpu_ack drop asynchronously. After release, a fresh word read completes normally.
